srdl2sv_ext_reg_bridge: RTL and testbench
=========================================

# srdl2sv_ext_reg_bridge

Register-bus slave that consumes the `b2r` request stream from the srdl2sv bus bridge and returns `r2b` responses. It forwards each in-range access to an external register block over a single-cycle request / acknowledge handshake. It also supplies the error response for out-of-range addresses and for accesses the external block never acknowledges. It sits directly downstream of the AHB-Lite bridge, in place of, or beside, generated register logic.

## Interface
Parameters:
- `BUS_BITS`, 32: data width; must match the upstream bridge.
- `ADDR_BASE`, 32'h0: byte base address of the external window; aligned to `ADDR_SIZE`.
- `ADDR_SIZE`, 32'h100: window size in bytes; power of two, at least `BUS_BITS/8`.
- `TIMEOUT_CYCLES`, 255: maximum WAIT cycles before an error response; range 1..65535.

Ports:
- `HCLK`, in, 1: the only clock.
- `HRESET`, in, 1: reset; synchronous, active-high.
- `b2r`, in, `b2r_t`: `w_vld`, `r_vld`, `addr`, `data`, `byte_en`.
- `r2b`, out, `r2b_t`: `rdy`, `err`, `data`.
- `ext_req`, out, 1: one-cycle request strobe.
- `ext_req_is_wr`, out, 1: 1 = write, 0 = read.
- `ext_addr`, out, `$clog2(ADDR_SIZE)`: offset in the window (`b2r.addr - ADDR_BASE`).
- `ext_wr_data`, out, `BUS_BITS`: write data, bus-lane aligned.
- `ext_wr_biten`, out, `BUS_BITS`: `byte_en` with each enable bit expanded to 8 bits.
- `ext_rd_ack`, in, 1: read done; `ext_rd_data` is valid in the same cycle.
- `ext_rd_data`, in, `BUS_BITS`: read data.
- `ext_wr_ack`, in, 1: write done.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE, with `w_vld` or `r_vld` set:
  - In range (`ADDR_BASE <= addr < ADDR_BASE+ADDR_SIZE`): register `addr` offset, `data`, expanded byte enables and direction, then go to REQ.
  - Out of range: go to RESP with `err=1`, `data=0`. No external request is issued.
- REQ: `ext_req=1` for exactly one cycle. An ack sampled in this cycle goes to RESP; otherwise go to WAIT.
- WAIT: `ext_req=0`; external outputs are held stable. The ack matching the direction goes to RESP with `err=0`.
  - A read ack captures `ext_rd_data` into the response register.
  - A write ack returns `data=0`.
- RESP: `r2b.rdy=1` for exactly one cycle, with `err` and `data` from their registers. Always returns to IDLE.
- The request in RESP is the one being completed and is never relaunched. A `vld` seen in the following IDLE cycle is a new access.
- Acks of the wrong direction, and acks in IDLE or RESP, are ignored.
- Both `w_vld` and `r_vld` set is illegal; the write wins.
- `vld` dropping during REQ or WAIT is illegal. The external access still completes and the response is presented regardless.
- `HRESET` in any state returns the FSM to IDLE next cycle. An in-flight external access is abandoned; a late ack arrives in IDLE and is ignored.

## Timing
- Reset values: all outputs 0 (`ext_req`, `ext_req_is_wr`, `ext_addr`, `ext_wr_data`, `ext_wr_biten`, `r2b.rdy`, `r2b.err`, `r2b.data`); FSM in IDLE.
- All outputs are registered; no combinational path from inputs to outputs.
- In-range access with `vld` sampled in IDLE at cycle N:
  - `ext_req` high at N+1.
  - Ack at cycle M ≥ N+1 gives `rdy` at M+1.
  - Minimum latency is 2 cycles, `vld` to `rdy`.
- Out-of-range access: `rdy`/`err` at N+1.
- Back-to-back accesses: at least one IDLE cycle separates RESP from the next REQ.

## Configuration
- `SRDL2SV_EXT_TIMEOUT_EN` defined:
  - A down-counter of width `$clog2(TIMEOUT_CYCLES+1)` loads `TIMEOUT_CYCLES` in REQ and decrements each WAIT cycle.
  - WAIT with count 0 and no ack goes to RESP with `err=1`, `data=0`.
  - An ack in the same cycle the count reaches 0 wins: `err=0`.
- Not defined: no counter, and WAIT persists until ack; `TIMEOUT_CYCLES` is unused.

## Structure
- Shared package `srdl2sv_if_pkg`: `b2r_t` and `r2b_t` (existing), plus a new `ext_fsm_t` enum (IDLE, REQ, WAIT, RESP).
- Sub-module `srdl2sv_ext_timeout`: loadable down-counter with an `expired` output, instantiated only under `SRDL2SV_EXT_TIMEOUT_EN`.
- The range check and byte-enable expansion stay local to the bridge.

## Test plan
- Write `addr=ADDR_BASE+8`, `data=32'hDEADBEEF`, `byte_en=4'b0011`, ack at N+3:
  - N+1: `ext_req=1`, `ext_addr=8`, `ext_wr_biten=32'h0000FFFF`.
  - N+4: `rdy=1`, `err=0`.
- Read `addr=ADDR_BASE+4`, `ext_rd_ack` in the REQ cycle with `ext_rd_data=32'h12345678` → `rdy` at N+2 with `data=32'h12345678`, `err=0`.
- Read `addr=ADDR_BASE+ADDR_SIZE` → `ext_req` never asserts; `rdy=1`, `err=1`, `data=0` at N+1.
- With the macro, `TIMEOUT_CYCLES=4`, no ack → `err=1` exactly at cycle N+6. Repeat with the ack on the final count cycle → `err=0`.
- `HRESET` pulsed during WAIT, then `ext_rd_ack` two cycles later → no `rdy`. A subsequent read completes normally.
- Write ack in the cycle after RESP while `w_vld` is still high (new access) → a second `ext_req` issues at the following cycle; the stray ack is ignored.

Source files
------------

// File: rtl/srdl2sv_if_pkg.sv
// Shared types between the srdl2sv bus bridge and register-side slaves.
// Bus request/response bundles plus the external-bridge FSM encoding.
package srdl2sv_if_pkg;

   localparam int BUS_W  = 32;
   localparam int ADDR_W = 32;

   typedef struct packed {
      logic              w_vld;
      logic              r_vld;
      logic [ADDR_W-1:0] addr;
      logic [BUS_W-1:0]  data;
      logic [BUS_W/8-1:0] byte_en;
   } b2r_t;

   typedef struct packed {
      logic             rdy;
      logic             err;
      logic [BUS_W-1:0] data;
   } r2b_t;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      RESP
   } ext_fsm_t;

endpackage

// File: rtl/srdl2sv_ext_timeout.sv
// Loadable down-counter bounding how long the bridge waits for an ack.
// Used only when SRDL2SV_EXT_TIMEOUT_EN is defined.
module srdl2sv_ext_timeout #(
   parameter int W    = 8,
   parameter int LOAD = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic dec,
   output logic expired
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= W'(LOAD);
      end else if (dec && count != '0) begin
         count <= count - W'(1);
      end
   end

   // The count reaches zero during the cycle that holds the last step
   assign expired = (count <= W'(1));

endmodule

// File: rtl/srdl2sv_ext_reg_bridge.sv
// b2r/r2b slave forwarding in-window accesses to an external register block.
// Optional ack timeout enabled by defining SRDL2SV_EXT_TIMEOUT_EN.
module srdl2sv_ext_reg_bridge
   import srdl2sv_if_pkg::*;
#(
   parameter int          BUS_BITS       = 32,
   parameter logic [31:0] ADDR_BASE      = 32'h0,
   parameter logic [31:0] ADDR_SIZE      = 32'h100,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic                         HCLK,
   input  logic                         HRESET,
   input  b2r_t                         b2r,
   output r2b_t                         r2b,
   output logic                         ext_req,
   output logic                         ext_req_is_wr,
   output logic [$clog2(ADDR_SIZE)-1:0] ext_addr,
   output logic [BUS_BITS-1:0]          ext_wr_data,
   output logic [BUS_BITS-1:0]          ext_wr_biten,
   input  logic                         ext_rd_ack,
   input  logic [BUS_BITS-1:0]          ext_rd_data,
   input  logic                         ext_wr_ack
);

   localparam int AW = $clog2(ADDR_SIZE);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be within 1..65535");
   end

   ext_fsm_t             state;
   ext_fsm_t             next;
   logic                 vld;
   logic                 in_range;
   logic [31:0]          off;
   logic [BUS_BITS-1:0]  biten_exp;
   logic                 ack_hit;
   logic                 expired;
   logic                 is_wr_q;
   logic [AW-1:0]        addr_q;
   logic [BUS_BITS-1:0]  wdata_q;
   logic [BUS_BITS-1:0]  biten_q;
   logic                 err_q;
   logic [BUS_BITS-1:0]  rdata_q;

   assign vld      = b2r.w_vld | b2r.r_vld;
   assign off      = b2r.addr - ADDR_BASE;
   assign in_range = (b2r.addr >= ADDR_BASE) && (off < ADDR_SIZE);
   assign ack_hit  = is_wr_q ? ext_wr_ack : ext_rd_ack;

   always_comb begin
      biten_exp = '0;
      for (int i = 0; i < BUS_BITS / 8; i++) begin
         biten_exp[i*8 +: 8] = {8{b2r.byte_en[i]}};
      end
   end

`ifdef SRDL2SV_EXT_TIMEOUT_EN
   srdl2sv_ext_timeout #(
      .W    ($clog2(TIMEOUT_CYCLES + 1)),
      .LOAD (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (HCLK),
      .rst     (HRESET),
      .load    (state == REQ),
      .dec     (state == WAIT),
      .expired (expired)
   );
`else
   assign expired = 1'b0;
`endif

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state <= IDLE;
      end else begin
         state <= next;
      end
   end

   always_comb begin
      next = state;
      unique case (state)
         IDLE: begin
            if (vld) begin
               next = in_range ? REQ : RESP;
            end
         end
         REQ:  next = ack_hit ? RESP : WAIT;
         WAIT: begin
            if (ack_hit || expired) begin
               next = RESP;
            end
         end
         RESP: next = IDLE;
         default: next = IDLE;
      endcase
   end

   always_comb begin
      ext_req       = (state == REQ);
      ext_req_is_wr = is_wr_q;
      ext_addr      = addr_q;
      ext_wr_data   = wdata_q;
      ext_wr_biten  = biten_q;
      r2b.rdy       = (state == RESP);
      r2b.err       = (state == RESP) & err_q;
      r2b.data      = (state == RESP) ? rdata_q : '0;
   end

   // Request fields launch in IDLE and stay frozen until the next launch
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         is_wr_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         biten_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (vld) begin
                  err_q   <= ~in_range;
                  rdata_q <= '0;
                  if (in_range) begin
                     is_wr_q <= b2r.w_vld;
                     addr_q  <= off[AW-1:0];
                     wdata_q <= b2r.data;
                     biten_q <= biten_exp;
                  end
               end
            end
            REQ, WAIT: begin
               if (ack_hit) begin
                  err_q   <= 1'b0;
                  rdata_q <= is_wr_q ? '0 : ext_rd_data;
               end else if (state == WAIT && expired) begin
                  err_q   <= 1'b1;
                  rdata_q <= '0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_srdl2sv_ext_reg_bridge.sv
// Directed bench for srdl2sv_ext_reg_bridge; timeout cases run when
// SRDL2SV_EXT_TIMEOUT_EN is defined.
module tb_srdl2sv_ext_reg_bridge;
   import srdl2sv_if_pkg::*;

   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam logic [31:0] SIZE = 32'h100;

   logic        HCLK = 1'b0;
   logic        HRESET = 1'b1;
   b2r_t        b2r = '0;
   r2b_t        r2b;
   logic        ext_req;
   logic        ext_req_is_wr;
   logic [7:0]  ext_addr;
   logic [31:0] ext_wr_data;
   logic [31:0] ext_wr_biten;
   logic        ext_rd_ack = 1'b0;
   logic [31:0] ext_rd_data = '0;
   logic        ext_wr_ack = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   srdl2sv_ext_reg_bridge #(
      .BUS_BITS       (32),
      .ADDR_BASE      (BASE),
      .ADDR_SIZE      (SIZE),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .HCLK          (HCLK),
      .HRESET        (HRESET),
      .b2r           (b2r),
      .r2b           (r2b),
      .ext_req       (ext_req),
      .ext_req_is_wr (ext_req_is_wr),
      .ext_addr      (ext_addr),
      .ext_wr_data   (ext_wr_data),
      .ext_wr_biten  (ext_wr_biten),
      .ext_rd_ack    (ext_rd_ack),
      .ext_rd_data   (ext_rd_data),
      .ext_wr_ack    (ext_wr_ack)
   );

   always #5 HCLK = ~HCLK;

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic test_reset();
      HRESET = 1'b1;
      tick();
      tick();
      HRESET = 1'b0;
      n_cmp++;
      if ({ext_req, ext_req_is_wr, ext_addr, ext_wr_data, ext_wr_biten} !== '0) begin
         n_bad++;
         $display("FAIL reset_ext: got %b %b %h %h %h want all 0",
                  ext_req, ext_req_is_wr, ext_addr, ext_wr_data, ext_wr_biten);
      end
      n_cmp++;
      if (r2b !== '0) begin
         n_bad++;
         $display("FAIL reset_r2b: got %h want 0", r2b);
      end
      tick();
   endtask

   task automatic test_write();
      b2r.w_vld = 1'b1;
      b2r.addr = BASE + 32'd8;
      b2r.data = 32'hDEAD_BEEF;
      b2r.byte_en = 4'b0011;
      tick();
      n_cmp++;
      if ({ext_req, ext_req_is_wr, ext_addr} !== {1'b1, 1'b1, 8'h08}) begin
         n_bad++;
         $display("FAIL wr_req: got req=%b wr=%b addr=%h want 1 1 08",
                  ext_req, ext_req_is_wr, ext_addr);
      end
      n_cmp++;
      if ({ext_wr_biten, ext_wr_data} !== {32'h0000_FFFF, 32'hDEAD_BEEF}) begin
         n_bad++;
         $display("FAIL wr_fields: got biten=%h data=%h want 0000ffff deadbeef",
                  ext_wr_biten, ext_wr_data);
      end
      ext_rd_ack = 1'b1;
      tick();
      ext_rd_ack = 1'b0;
      n_cmp++;
      if ({ext_req, ext_addr, r2b.rdy} !== {1'b0, 8'h08, 1'b0}) begin
         n_bad++;
         $display("FAIL wr_wait: got req=%b addr=%h rdy=%b want 0 08 0",
                  ext_req, ext_addr, r2b.rdy);
      end
      tick();
      ext_wr_ack = 1'b1;
      n_cmp++;
      if (r2b.rdy !== 1'b0) begin
         n_bad++;
         $display("FAIL wr_wrong_ack: got rdy=%b want 0", r2b.rdy);
      end
      tick();
      ext_wr_ack = 1'b0;
      n_cmp++;
      if (r2b !== {1'b1, 1'b0, 32'h0}) begin
         n_bad++;
         $display("FAIL wr_resp: got %h want 200000000", r2b);
      end
      b2r = '0;
      tick();
      n_cmp++;
      if ({r2b.rdy, ext_req} !== 2'b00) begin
         n_bad++;
         $display("FAIL wr_idle: got rdy=%b req=%b want 0 0", r2b.rdy, ext_req);
      end
   endtask

   task automatic test_read_fast();
      b2r.r_vld = 1'b1;
      b2r.addr = BASE + 32'd4;
      tick();
      n_cmp++;
      if ({ext_req, ext_req_is_wr, ext_addr} !== {1'b1, 1'b0, 8'h04}) begin
         n_bad++;
         $display("FAIL rd_req: got req=%b wr=%b addr=%h want 1 0 04",
                  ext_req, ext_req_is_wr, ext_addr);
      end
      ext_rd_ack = 1'b1;
      ext_rd_data = 32'h1234_5678;
      tick();
      ext_rd_ack = 1'b0;
      ext_rd_data = '0;
      n_cmp++;
      if (r2b !== {1'b1, 1'b0, 32'h1234_5678}) begin
         n_bad++;
         $display("FAIL rd_resp: got %h want 212345678", r2b);
      end
      b2r = '0;
      tick();
      n_cmp++;
      if (r2b.rdy !== 1'b0) begin
         n_bad++;
         $display("FAIL rd_rdy_once: got rdy=%b want 0", r2b.rdy);
      end
   endtask

   task automatic test_range();
      b2r.r_vld = 1'b1;
      b2r.addr = BASE + SIZE;
      tick();
      n_cmp++;
      if ({ext_req, r2b} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
         n_bad++;
         $display("FAIL oor_high: got req=%b r2b=%h want 0 300000000", ext_req, r2b);
      end
      b2r = '0;
      tick();
      b2r.w_vld = 1'b1;
      b2r.addr = BASE - 32'd4;
      tick();
      n_cmp++;
      if ({ext_req, r2b.rdy, r2b.err} !== 3'b011) begin
         n_bad++;
         $display("FAIL oor_low: got req=%b rdy=%b err=%b want 0 1 1",
                  ext_req, r2b.rdy, r2b.err);
      end
      b2r = '0;
      tick();
      b2r.r_vld = 1'b1;
      b2r.addr = BASE + SIZE - 32'd4;
      tick();
      n_cmp++;
      if ({ext_req, ext_addr} !== {1'b1, 8'hFC}) begin
         n_bad++;
         $display("FAIL top_word: got req=%b addr=%h want 1 fc", ext_req, ext_addr);
      end
      ext_rd_ack = 1'b1;
      ext_rd_data = 32'hCAFE_F00D;
      tick();
      ext_rd_ack = 1'b0;
      n_cmp++;
      if (r2b !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin
         n_bad++;
         $display("FAIL top_word_resp: got %h want 2cafef00d", r2b);
      end
      b2r = '0;
      tick();
   endtask

   task automatic test_back_to_back();
      b2r.w_vld = 1'b1;
      b2r.addr = BASE + 32'hC;
      b2r.data = 32'h1111_2222;
      b2r.byte_en = 4'hF;
      tick();
      ext_wr_ack = 1'b1;
      tick();
      ext_wr_ack = 1'b0;
      n_cmp++;
      if (r2b.rdy !== 1'b1) begin
         n_bad++;
         $display("FAIL b2b_first: got rdy=%b want 1", r2b.rdy);
      end
      b2r.data = 32'h3333_4444;
      b2r.byte_en = 4'b0100;
      tick();
      n_cmp++;
      if ({ext_req, r2b.rdy} !== 2'b00) begin
         n_bad++;
         $display("FAIL b2b_gap: got req=%b rdy=%b want 0 0", ext_req, r2b.rdy);
      end
      ext_wr_ack = 1'b1;
      tick();
      ext_wr_ack = 1'b0;
      n_cmp++;
      if ({ext_req, r2b.rdy, ext_wr_data, ext_wr_biten}
          !== {2'b10, 32'h3333_4444, 32'h00FF_0000}) begin
         n_bad++;
         $display("FAIL b2b_second: got req=%b rdy=%b data=%h biten=%h want 1 0 33334444 00ff0000",
                  ext_req, r2b.rdy, ext_wr_data, ext_wr_biten);
      end
      tick();
      n_cmp++;
      if ({ext_req, r2b.rdy} !== 2'b00) begin
         n_bad++;
         $display("FAIL b2b_stray: got req=%b rdy=%b want 0 0", ext_req, r2b.rdy);
      end
      ext_wr_ack = 1'b1;
      tick();
      ext_wr_ack = 1'b0;
      n_cmp++;
      if (r2b !== {1'b1, 1'b0, 32'h0}) begin
         n_bad++;
         $display("FAIL b2b_resp: got %h want 200000000", r2b);
      end
      b2r = '0;
      tick();
   endtask

   task automatic test_reset_in_wait();
      logic saw;
      b2r.r_vld = 1'b1;
      b2r.addr = BASE + 32'h10;
      tick();
      tick();
      HRESET = 1'b1;
      b2r = '0;
      tick();
      HRESET = 1'b0;
      n_cmp++;
      if ({ext_req, ext_addr, r2b.rdy} !== '0) begin
         n_bad++;
         $display("FAIL rst_wait: got req=%b addr=%h rdy=%b want 0 00 0",
                  ext_req, ext_addr, r2b.rdy);
      end
      tick();
      ext_rd_ack = 1'b1;
      ext_rd_data = 32'hBAD0_BAD0;
      saw = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         ext_rd_ack = 1'b0;
         saw = saw | r2b.rdy | ext_req;
      end
      n_cmp++;
      if (saw !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_late_ack: got rdy_or_req=%b want 0", saw);
      end
      b2r.r_vld = 1'b1;
      b2r.addr = BASE + 32'h14;
      tick();
      ext_rd_ack = 1'b1;
      ext_rd_data = 32'hAAAA_5555;
      tick();
      ext_rd_ack = 1'b0;
      n_cmp++;
      if (r2b !== {1'b1, 1'b0, 32'hAAAA_5555}) begin
         n_bad++;
         $display("FAIL rst_recover: got %h want 2aaaa5555", r2b);
      end
      b2r = '0;
      tick();
   endtask

`ifdef SRDL2SV_EXT_TIMEOUT_EN
   task automatic test_timeout();
      b2r.r_vld = 1'b1;
      b2r.addr = BASE + 32'h20;
      tick();
      for (int i = 0; i < 4; i++) tick();
      n_cmp++;
      if (r2b.rdy !== 1'b0) begin
         n_bad++;
         $display("FAIL to_early: got rdy=%b at N+5 want 0", r2b.rdy);
      end
      tick();
      n_cmp++;
      if (r2b !== {1'b1, 1'b1, 32'h0}) begin
         n_bad++;
         $display("FAIL to_expire: got %h at N+6 want 300000000", r2b);
      end
      b2r = '0;
      tick();
      b2r.r_vld = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) tick();
      ext_rd_ack = 1'b1;
      ext_rd_data = 32'h0BAD_CAFE;
      tick();
      ext_rd_ack = 1'b0;
      n_cmp++;
      if (r2b !== {1'b1, 1'b0, 32'h0BAD_CAFE}) begin
         n_bad++;
         $display("FAIL to_ack_wins: got %h want 20badcafe", r2b);
      end
      b2r = '0;
      tick();
   endtask
`else
   task automatic test_no_timeout();
      logic saw;
      b2r.r_vld = 1'b1;
      b2r.addr = BASE + 32'h20;
      tick();
      saw = 1'b0;
      for (int i = 0; i < 300; i++) begin
         tick();
         saw = saw | r2b.rdy;
      end
      n_cmp++;
      if (saw !== 1'b0) begin
         n_bad++;
         $display("FAIL wait_forever: got rdy=%b want 0", saw);
      end
      ext_rd_ack = 1'b1;
      ext_rd_data = 32'h0BAD_CAFE;
      tick();
      ext_rd_ack = 1'b0;
      n_cmp++;
      if (r2b !== {1'b1, 1'b0, 32'h0BAD_CAFE}) begin
         n_bad++;
         $display("FAIL wait_ack: got %h want 20badcafe", r2b);
      end
      b2r = '0;
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_write();
      test_read_fast();
      test_range();
      test_back_to_back();
      test_reset_in_wait();
`ifdef SRDL2SV_EXT_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
